red_pitaya_enable_seq: RTL



---
 rtl/red_pitaya_enable_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/red_pitaya_enable_seq.sv
// Enable sequencer: applies a requested enable mask one bit at a time with a
// fixed settle interval, tearing down enabled bits before bringing new ones up.
module red_pitaya_enable_seq #(
  parameter int N_SUB  = 4,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SUB-1:0] req_mask_i,
  input  logic             sleep_i,
  output logic [N_SUB-1:0] enable_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [N_SUB-1:0] req_r, enable_r, enable_nxt_s;
  logic [N_SUB-1:0] diff_s, off_s, on_s, step_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             busy_r, done_r, done_nxt_s;

  function automatic logic [N_SUB-1:0] highest_bit(input logic [N_SUB-1:0] v);
    logic [N_SUB-1:0] r;
    r = '0;
    for (int i = 0; i < N_SUB; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N_SUB-1:0] lowest_bit(input logic [N_SUB-1:0] v);
    logic [N_SUB-1:0] r;
    r = '0;
    for (int i = N_SUB - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign diff_s = req_r ^ enable_r;
  assign off_s  = diff_s & enable_r;
  assign on_s   = diff_s & ~enable_r;

  // Pick the single bit to toggle: tear-down (highest first) wins over bring-up (lowest first)
  always_comb begin
    step_s = '0;
    if (off_s != '0) begin
      step_s = highest_bit(off_s);
    end else begin
      step_s = lowest_bit(on_s);
    end
  end

  // State register plus registered datapath and outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r  <= IDLE;
      req_r    <= '0;
      enable_r <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      req_r    <= sleep_i ? '0 : req_mask_i;
      enable_r <= enable_nxt_s;
      cnt_r    <= cnt_nxt_s;
      busy_r   <= (state_nxt_s == WAIT);
      done_r   <= done_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (diff_s != '0) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if ((cnt_r != '0) || (diff_s != '0)) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath logic: the running settle interval always completes before the next step
  always_comb begin
    enable_nxt_s = enable_r;
    cnt_nxt_s    = cnt_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (diff_s != '0) begin
          enable_nxt_s = enable_r ^ step_s;
          cnt_nxt_s    = CNT_LOAD;
        end else begin
          cnt_nxt_s    = cnt_r;
        end
      end
      WAIT: begin
        if (cnt_r != '0) begin
          cnt_nxt_s = cnt_r - CW'(1);
        end else if (diff_s != '0) begin
          enable_nxt_s = enable_r ^ step_s;
          cnt_nxt_s    = CNT_LOAD;
        end else begin
          done_nxt_s   = 1'b1;
        end
      end
      default: begin
        enable_nxt_s = enable_r;
        cnt_nxt_s    = cnt_r;
      end
    endcase
  end

  assign enable_o = enable_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;

endmodule
